// File: rtl/rv32_pkg.sv
// Shared types for the rv32 bus arbiter: FSM state and grant owner encodings,
// plus the two-way round-robin pick used when both requesters are pending.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [3:0] FETCH_BE = 4'b1111;

    // On a tie the requester that did not win last time gets the bus.
    function automatic grant_e rr_pick(input logic instr_pend, input logic data_pend,
                                       input grant_e last_grant);
        if (instr_pend && data_pend) begin
            return (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        end
        if (data_pend) begin
            return GNT_DATA;
        end
        return GNT_INSTR;
    endfunction

endpackage

// File: rtl/rv32_mod_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between fetch and LSU.
// Optional bus watchdog enabled by defining RV32_BUS_ARB_TIMEOUT_EN.
module rv32_mod_bus_arbiter
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data_o,
    output logic        instr_ack,
    output logic        instr_err,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_i,
    output logic [31:0] data_data_o,
    output logic        data_ack,
    output logic        data_err,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack,
    input  logic        bus_err
);

    arb_state_e state;
    grant_e     last_grant;
    grant_e     pick;
    logic       timeout_hit;

    always_comb begin
        pick = rr_pick(instr_req, data_req, last_grant);
    end

`ifdef RV32_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             busy;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    // Held at zero outside BUSY so every transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || !busy) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = busy && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GNT_INSTR;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            bus_be       <= 4'b0000;
            bus_addr     <= 32'h0;
            bus_data_o   <= 32'h0;
            instr_ack    <= 1'b0;
            instr_err    <= 1'b0;
            data_ack     <= 1'b0;
            data_err     <= 1'b0;
            instr_data_o <= 32'h0;
            data_data_o  <= 32'h0;
        end else begin
            instr_ack <= 1'b0;
            instr_err <= 1'b0;
            data_ack  <= 1'b0;
            data_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        last_grant <= pick;
                        bus_req    <= 1'b1;
                        if (pick == GNT_DATA) begin
                            bus_wr     <= data_wr;
                            bus_be     <= data_be;
                            bus_addr   <= data_addr;
                            bus_data_o <= data_data_i;
                            state      <= BUSY_D;
                        end else begin
                            bus_wr     <= 1'b0;
                            bus_be     <= FETCH_BE;
                            bus_addr   <= instr_addr;
                            bus_data_o <= 32'h0;
                            state      <= BUSY_I;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    // Error (or watchdog) takes priority over a simultaneous ack.
                    if (bus_err || timeout_hit) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                        if (state == BUSY_D) begin
                            data_err <= 1'b1;
                        end else begin
                            instr_err <= 1'b1;
                        end
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                        if (state == BUSY_D) begin
                            data_ack    <= 1'b1;
                            data_data_o <= bus_data_i;
                        end else begin
                            instr_ack    <= 1'b1;
                            instr_data_o <= bus_data_i;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Directed bench for rv32_mod_bus_arbiter with a transaction-level reference model.
// Timeout scenario runs only when RV32_BUS_ARB_TIMEOUT_EN is defined.
module tb_rv32_mod_bus_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_data_o;
    logic        instr_ack;
    logic        instr_err;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_data_i;
    logic [31:0] data_data_o;
    logic        data_ack;
    logic        data_err;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    rv32_mod_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_data_o (instr_data_o),
        .instr_ack    (instr_ack),
        .instr_err    (instr_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_data_i  (data_data_i),
        .data_data_o  (data_data_o),
        .data_ack     (data_ack),
        .data_err     (data_err),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_be       (bus_be),
        .bus_addr     (bus_addr),
        .bus_data_o   (bus_data_o),
        .bus_data_i   (bus_data_i),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, one quiet cycle after each
    // response, requests considered only when nothing is outstanding or quiet.
    bit          m_seen = 0;
    bit          m_out;
    int          m_owner;     // 0 = fetch, 1 = LSU
    int          m_last;
    int          m_quiet;
    int          m_wait;
    bit          m_wr;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_iack, m_ierr, m_dack, m_derr;
    logic [31:0] m_idata, m_ddata;

    always @(posedge clk) begin
        bit expired;
        m_iack = 0; m_ierr = 0; m_dack = 0; m_derr = 0;
        if (reset) begin
            m_out = 0; m_quiet = 0; m_last = 0; m_wait = 0;
            m_idata = 32'h0; m_ddata = 32'h0;
        end else if (m_out) begin
            m_wait++;
`ifdef RV32_BUS_ARB_TIMEOUT_EN
            expired = (m_wait >= TO);
`else
            expired = 0;
`endif
            if (bus_err || expired) begin
                if (m_owner == 1) m_derr = 1; else m_ierr = 1;
                m_out = 0; m_quiet = 1;
            end else if (bus_ack) begin
                if (m_owner == 1) begin m_dack = 1; m_ddata = bus_data_i; end
                else begin m_iack = 1; m_idata = bus_data_i; end
                m_out = 0; m_quiet = 1;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (instr_req || data_req) begin
            if (instr_req && data_req) m_owner = (m_last == 0) ? 1 : 0;
            else m_owner = data_req ? 1 : 0;
            m_last = m_owner;
            m_out  = 1;
            m_wait = 0;
            if (m_owner == 1) begin
                m_wr = data_wr; m_be = data_be; m_addr = data_addr; m_wdata = data_data_i;
            end else begin
                m_wr = 0; m_be = 4'hF; m_addr = instr_addr; m_wdata = 32'h0;
            end
        end
        m_seen = 1;
    end

    always @(negedge clk) begin
        if (m_seen) begin
            chk("m_bus_req",   {31'h0, bus_req},   {31'h0, m_out});
            chk("m_instr_ack", {31'h0, instr_ack}, {31'h0, m_iack});
            chk("m_instr_err", {31'h0, instr_err}, {31'h0, m_ierr});
            chk("m_data_ack",  {31'h0, data_ack},  {31'h0, m_dack});
            chk("m_data_err",  {31'h0, data_err},  {31'h0, m_derr});
            chk("m_instr_data", instr_data_o, m_idata);
            chk("m_data_data",  data_data_o,  m_ddata);
            chk("m_one_pulse", {31'h0, (32'(instr_ack) + 32'(instr_err) + 32'(data_ack)
                                        + 32'(data_err)) > 1}, 32'h0);
            if (m_out) begin
                chk("m_bus_wr",   {31'h0, bus_wr}, {31'h0, m_wr});
                chk("m_bus_be",   {28'h0, bus_be}, {28'h0, m_be});
                chk("m_bus_addr", bus_addr, m_addr);
                if (m_owner == 1) chk("m_bus_wdata", bus_data_o, m_wdata);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_req"},  {31'h0, bus_req}, 32'h0);
        chk({tag, "_bus_wr"},   {31'h0, bus_wr},  32'h0);
        chk({tag, "_bus_be"},   {28'h0, bus_be},  32'h0);
        chk({tag, "_bus_addr"}, bus_addr,         32'h0);
        chk({tag, "_bus_wd"},   bus_data_o,       32'h0);
        chk({tag, "_pulses"},   {28'h0, instr_ack, instr_err, data_ack, data_err}, 32'h0);
        chk({tag, "_idata"},    instr_data_o,     32'h0);
        chk({tag, "_ddata"},    data_data_o,      32'h0);
    endtask

    logic [31:0] grants[$];
    int          pulses_seen;
    int          err_at;

    initial begin
        reset = 1'b1;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_wr = 0; data_be = 0; data_addr = 0; data_data_i = 0;
        bus_data_i = 0; bus_ack = 0; bus_err = 0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single fetch, ack on the second BUSY cycle.
        instr_req = 1; instr_addr = 32'h0000_0100;
        tick();
        chk("f_req_c1", {31'h0, bus_req}, 32'h1);
        chk("f_wr",     {31'h0, bus_wr},  32'h0);
        chk("f_be",     {28'h0, bus_be},  32'hF);
        chk("f_addr",   bus_addr,         32'h0000_0100);
        tick();
        chk("f_req_c2", {31'h0, bus_req}, 32'h1);
        bus_ack = 1; bus_data_i = 32'hDEAD_BEEF;
        tick();
        bus_ack = 0; bus_data_i = 32'h0; instr_req = 0;
        chk("f_ack_c3", {31'h0, instr_ack}, 32'h1);
        chk("f_data",   instr_data_o,       32'hDEAD_BEEF);
        chk("f_req_c3", {31'h0, bus_req},   32'h0);
        tick();
        chk("f_ack_c4", {31'h0, instr_ack}, 32'h0);

        // LSU write with zero read data on the bus.
        data_req = 1; data_wr = 1; data_be = 4'b0011;
        data_addr = 32'h2000_0004; data_data_i = 32'h1234_5678;
        tick();
        chk("w_wr",    {31'h0, bus_wr}, 32'h1);
        chk("w_be",    {28'h0, bus_be}, 32'h3);
        chk("w_addr",  bus_addr,        32'h2000_0004);
        chk("w_wdata", bus_data_o,      32'h1234_5678);
        tick();
        chk("w_addr2", bus_addr,        32'h2000_0004);
        bus_ack = 1;
        tick();
        bus_ack = 0; data_req = 0;
        chk("w_ack",   {31'h0, data_ack}, 32'h1);
        chk("w_ddata", data_data_o,       32'h0);
        tick();

        // LSU read to load a known value, then ack+err together.
        data_req = 1; data_wr = 0; data_be = 4'hF; data_addr = 32'h3000_0000;
        tick();
        bus_ack = 1; bus_data_i = 32'hCAFE_F00D;
        tick();
        bus_ack = 0; data_req = 0;
        chk("r_data", data_data_o, 32'hCAFE_F00D);
        tick();
        data_req = 1; data_addr = 32'h3000_0010;
        tick();
        bus_ack = 1; bus_err = 1; bus_data_i = 32'h1111_1111;
        tick();
        bus_ack = 0; bus_err = 0; data_req = 0;
        chk("e_err",   {31'h0, data_err}, 32'h1);
        chk("e_ack",   {31'h0, data_ack}, 32'h0);
        chk("e_ddata", data_data_o,       32'hCAFE_F00D);
        tick();

        // Contention from a fresh reset with a zero-wait bus.
        reset = 1;
        tick();
        check_all_zero("reset2");
        reset = 0;
        instr_req = 1; instr_addr = 32'h0000_0100;
        data_req = 1; data_wr = 0; data_be = 4'hF; data_addr = 32'h4000_0000;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (bus_req) begin
                grants.push_back(bus_addr);
                bus_ack = 1; bus_data_i = 32'h1000_0000 + 32'(k);
            end else begin
                bus_ack = 0;
            end
        end
        instr_req = 0; data_req = 0;
        tick();
        bus_ack = 0;
        chk("c_ngrants", {31'h0, grants.size() >= 4}, 32'h1);
        if (grants.size() >= 4) begin
            chk("c_g0", grants[0], 32'h4000_0000);
            chk("c_g1", grants[1], 32'h0000_0100);
            chk("c_g2", grants[2], 32'h4000_0000);
            chk("c_g3", grants[3], 32'h0000_0100);
        end
        repeat (4) tick();

        // Reset while an LSU write is on the bus.
        data_req = 1; data_wr = 1; data_be = 4'hF;
        data_addr = 32'h5000_0000; data_data_i = 32'h0000_0055;
        tick();
        chk("rm_busy", {31'h0, bus_req}, 32'h1);
        reset = 1;
        tick();
        check_all_zero("rm");
        reset = 0; data_req = 0;
        pulses_seen = 0;
        bus_ack = 1;
        tick();
        bus_ack = 0;
        for (int k = 0; k < 5; k++) begin
            pulses_seen += 32'(instr_ack) + 32'(instr_err) + 32'(data_ack) + 32'(data_err);
            tick();
        end
        chk("rm_no_resp", 32'(pulses_seen), 32'h0);

`ifdef RV32_BUS_ARB_TIMEOUT_EN
        // Silent bus: watchdog error must land TO+1 cycles after the grant cycle.
        instr_req = 1; instr_addr = 32'h0000_0600;
        err_at = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (instr_err && err_at < 0) err_at = n;
        end
        instr_req = 0;
        chk("t_err_cycle", 32'(err_at), 32'(TO + 1));
        data_req = 1; data_wr = 0; data_addr = 32'h7000_0000;
        tick();
        chk("t_next_req", {31'h0, bus_req}, 32'h1);
        bus_ack = 1; bus_data_i = 32'h7777_0000;
        tick();
        bus_ack = 0; data_req = 0;
        chk("t_next_ack", {31'h0, data_ack}, 32'h1);
        tick();
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
